// File: rtl/move_command_executor.sv
// Rover move executor: latches a 12-bit move command, turns in place, pauses, then drives forward.
// Optional CMD_QUEUE_EN adds a one-deep holding register for commands that arrive while busy.
module move_command_executor #(
    parameter int unsigned TURN_TICKS  = 1350000,
    parameter int unsigned UNIT_TICKS  = 2700000,
    parameter int unsigned PAUSE_TICKS = 270000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [11:0] move_command,
    output logic        busy,
    output logic        move_done,
    output logic        cmd_error,
    output logic        cmd_dropped,
    output logic [1:0]  motor_left,
    output logic [1:0]  motor_right,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StTurn  = 3'd1,
        StPause = 3'd2,
        StDrive = 3'd3,
        StDone  = 3'd4
    } state_t;

    localparam logic [1:0]  MotStop   = 2'b00;
    localparam logic [1:0]  MotFwd    = 2'b01;
    localparam logic [1:0]  MotRev    = 2'b10;
    localparam logic [31:0] TurnLast  = 32'(TURN_TICKS - 1);
    localparam logic [31:0] UnitLast  = 32'(UNIT_TICKS - 1);
    localparam logic [31:0] PauseLast = 32'(PAUSE_TICKS - 1);

    state_t      r_state;
    logic [31:0] r_tick;
    logic [6:0]  r_step;
    logic [6:0]  r_dist;
    logic        r_busy;
    logic        r_move_done;
    logic        r_cmd_error;
    logic        r_cmd_dropped;
    logic [1:0]  r_motor_left;
    logic [1:0]  r_motor_right;

    logic [11:0] w_src;
    logic        w_accept;
    logic        w_drop;
    logic [4:0]  w_idx;
    logic [6:0]  w_dist;
    logic        w_illegal;

`ifdef CMD_QUEUE_EN
    logic [11:0] r_hold;
    logic        r_hold_valid;
    logic        w_capture;

    // A command strobed in DONE with an empty holding register is taken as if it had been held.
    assign w_src     = r_hold_valid ? r_hold : move_command;
    assign w_accept  = ((r_state == StIdle) && cmd_valid) ||
                       ((r_state == StDone) && (r_hold_valid || cmd_valid));
    assign w_capture = cmd_valid && !r_hold_valid &&
                       ((r_state == StTurn) || (r_state == StPause) || (r_state == StDrive));
    assign w_drop    = cmd_valid && r_hold_valid && (r_state != StIdle);
`else
    assign w_src    = move_command;
    assign w_accept = (r_state == StIdle) && cmd_valid;
    assign w_drop   = cmd_valid && (r_state != StIdle);
`endif

    assign w_idx     = w_src[11:7];
    assign w_dist    = w_src[6:0];
    assign w_illegal = (w_idx > 5'd23);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= StIdle;
            r_tick        <= '0;
            r_step        <= '0;
            r_dist        <= '0;
            r_busy        <= 1'b0;
            r_move_done   <= 1'b0;
            r_cmd_error   <= 1'b0;
            r_cmd_dropped <= 1'b0;
            r_motor_left  <= MotStop;
            r_motor_right <= MotStop;
`ifdef CMD_QUEUE_EN
            r_hold        <= '0;
            r_hold_valid  <= 1'b0;
`endif
        end else begin
            r_move_done   <= 1'b0;
            r_cmd_error   <= 1'b0;
            r_cmd_dropped <= w_drop;
`ifdef CMD_QUEUE_EN
            if (w_capture) begin
                r_hold       <= move_command;
                r_hold_valid <= 1'b1;
            end else if (w_accept && (r_state == StDone)) begin
                r_hold_valid <= 1'b0;
            end
`endif
            if (w_accept) begin
                r_dist <= w_dist;
                if (w_illegal) begin
                    r_state       <= StIdle;
                    r_cmd_error   <= 1'b1;
                    r_busy        <= 1'b0;
                    r_motor_left  <= MotStop;
                    r_motor_right <= MotStop;
                end else if (w_idx != 5'd0) begin
                    r_state       <= StTurn;
                    r_step        <= {2'b00, w_idx};
                    r_tick        <= TurnLast;
                    r_busy        <= 1'b1;
                    r_motor_left  <= MotFwd;
                    r_motor_right <= MotRev;
                end else if (w_dist != 7'd0) begin
                    r_state       <= StDrive;
                    r_step        <= w_dist;
                    r_tick        <= UnitLast;
                    r_busy        <= 1'b1;
                    r_motor_left  <= MotFwd;
                    r_motor_right <= MotFwd;
                end else begin
                    r_state       <= StDone;
                    r_move_done   <= 1'b1;
                    r_busy        <= 1'b0;
                    r_motor_left  <= MotStop;
                    r_motor_right <= MotStop;
                end
            end else begin
                unique case (r_state)
                    StIdle: begin
                        r_busy <= 1'b0;
                    end
                    // Step counter counts down turn steps; tick counter counts cycles per step.
                    StTurn: begin
                        if (r_tick == 32'd0) begin
                            if (r_step == 7'd1) begin
                                r_motor_left  <= MotStop;
                                r_motor_right <= MotStop;
                                if (r_dist != 7'd0) begin
                                    r_state <= StPause;
                                    r_tick  <= PauseLast;
                                end else begin
                                    r_state     <= StDone;
                                    r_move_done <= 1'b1;
                                    r_busy      <= 1'b0;
                                end
                            end else begin
                                r_step <= r_step - 7'd1;
                                r_tick <= TurnLast;
                            end
                        end else begin
                            r_tick <= r_tick - 32'd1;
                        end
                    end
                    StPause: begin
                        if (r_tick == 32'd0) begin
                            r_state       <= StDrive;
                            r_step        <= r_dist;
                            r_tick        <= UnitLast;
                            r_motor_left  <= MotFwd;
                            r_motor_right <= MotFwd;
                        end else begin
                            r_tick <= r_tick - 32'd1;
                        end
                    end
                    StDrive: begin
                        if (r_tick == 32'd0) begin
                            if (r_step == 7'd1) begin
                                r_state       <= StDone;
                                r_move_done   <= 1'b1;
                                r_busy        <= 1'b0;
                                r_motor_left  <= MotStop;
                                r_motor_right <= MotStop;
                            end else begin
                                r_step <= r_step - 7'd1;
                                r_tick <= UnitLast;
                            end
                        end else begin
                            r_tick <= r_tick - 32'd1;
                        end
                    end
                    StDone: begin
                        r_state       <= StIdle;
                        r_busy        <= 1'b0;
                        r_motor_left  <= MotStop;
                        r_motor_right <= MotStop;
                    end
                    default: begin
                        r_state       <= StIdle;
                        r_busy        <= 1'b0;
                        r_motor_left  <= MotStop;
                        r_motor_right <= MotStop;
                    end
                endcase
            end
        end
    end

    assign busy        = r_busy;
    assign move_done   = r_move_done;
    assign cmd_error   = r_cmd_error;
    assign cmd_dropped = r_cmd_dropped;
    assign motor_left  = r_motor_left;
    assign motor_right = r_motor_right;
    assign state       = r_state;

endmodule

// File: tb/tb_move_command_executor.sv
// Bench for move_command_executor: a monitor turns motor run-lengths and pulses into event codes
// that are checked against a scoreboard queue filled by the directed stimulus.
module tb_move_command_executor;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [11:0] move_command = '0;
    logic        busy;
    logic        move_done;
    logic        cmd_error;
    logic        cmd_dropped;
    logic [1:0]  motor_left;
    logic [1:0]  motor_right;
    logic [2:0]  state;

    // Event codes: kind*1000 + length. 1=turn run, 2=forward run, 9=other run,
    // 4000=move_done, 5000=cmd_error, 6000=cmd_dropped.
    int exp_q[$];
    int st_log[$];
    int n_checks = 0;
    int n_fail   = 0;

    move_command_executor #(
        .TURN_TICKS (4),
        .UNIT_TICKS (3),
        .PAUSE_TICKS(2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .move_command(move_command),
        .busy        (busy),
        .move_done   (move_done),
        .cmd_error   (cmd_error),
        .cmd_dropped (cmd_dropped),
        .motor_left  (motor_left),
        .motor_right (motor_right),
        .state       (state)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic emit(input int code);
        int e;
        if (exp_q.size() == 0) begin
            check("unexpected_event", code, -1);
        end else begin
            e = exp_q.pop_front();
            check("event", code, e);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    logic [3:0] prev_pat = 4'b0000;
    int         run_len  = 0;
    logic [2:0] prev_st  = 3'd0;
    always @(negedge clock) begin
        logic [3:0] cur;
        int         kind;
        cur = {motor_left, motor_right};
        if (!reset) begin
            prev_pat = 4'b0000;
            run_len  = 0;
            prev_st  = 3'd0;
        end else begin
            if (cur != prev_pat && prev_pat != 4'b0000) begin
                kind = (prev_pat == 4'b0110) ? 1 : (prev_pat == 4'b0101) ? 2 : 9;
                emit(kind * 1000 + run_len);
            end
            if (cur == prev_pat) run_len++;
            else run_len = 1;
            prev_pat = cur;
            if (move_done)   emit(4000);
            if (cmd_error)   emit(5000);
            if (cmd_dropped) emit(6000);
            if (state != prev_st) st_log.push_back(int'(state));
            prev_st = state;
        end
    end

    task automatic send(input logic [11:0] cmd);
        @(negedge clock);
        #1;
        cmd_valid    = 1'b1;
        move_command = cmd;
        @(negedge clock);
        #1;
        cmd_valid    = 1'b0;
        move_command = '0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || state != 3'd0) && n < budget) begin
            @(negedge clock);
            n++;
        end
        #1;
        check("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        int exp_seq[5];
        exp_seq = '{1, 2, 3, 4, 0};

        // Reset state
        #1;
        check("reset_outputs", int'({busy, move_done, cmd_error, cmd_dropped,
                                     motor_left, motor_right, state}), 0);
        repeat (3) @(negedge clock);
        #1;
        reset = 1'b1;

        // 12'h005: forward 15 cycles
        exp_q.push_back(2015);
        exp_q.push_back(4000);
        send(12'h005);
        check("fwd_busy", int'(busy), 1);
        check("fwd_state", int'(state), 3);
        repeat (7) @(negedge clock);
        #1;
        check("fwd_busy_mid", int'(busy), 1);
        drain(100);

        // 12'h100: turn 8 cycles only
        exp_q.push_back(1008);
        exp_q.push_back(4000);
        send(12'h100);
        check("turn_state", int'(state), 1);
        check("turn_motors", int'({motor_left, motor_right}), 6);
        drain(100);

        // 12'h183: turn 12, pause 2, forward 9
        st_log.delete();
        exp_q.push_back(1012);
        exp_q.push_back(2009);
        exp_q.push_back(4000);
        send(12'h183);
        drain(200);
        repeat (2) @(negedge clock);
        #1;
        check("state_seq_len", st_log.size(), 5);
        for (int i = 0; i < 5 && i < st_log.size(); i++) check("state_seq", st_log[i], exp_seq[i]);

        // 12'hC00: illegal index
        exp_q.push_back(5000);
        send(12'hC00);
        check("illegal_busy", int'(busy), 0);
        check("illegal_motors", int'({motor_left, motor_right}), 0);
        check("illegal_state", int'(state), 0);
        drain(20);

        // 12'h000: move_done one cycle after accept
        exp_q.push_back(4000);
        send(12'h000);
        check("zero_done", int'(move_done), 1);
        check("zero_busy", int'(busy), 0);
        drain(20);

        // 12'h07F aborted by reset at drive cycle 50
        send(12'h07F);
        repeat (49) @(negedge clock);
        #1;
        check("long_motors_pre", int'({motor_left, motor_right}), 5);
        reset = 1'b0;
        #1;
        check("abort_motors", int'({motor_left, motor_right}), 0);
        check("abort_state", int'(state), 0);
        repeat (2) @(negedge clock);
        #1;
        reset = 1'b1;
        exp_q.push_back(2003);
        exp_q.push_back(4000);
        send(12'h001);
        drain(50);

        // 12'h005 then 12'h002 during drive cycle 5
`ifdef CMD_QUEUE_EN
        exp_q.push_back(2015);
        exp_q.push_back(4000);
        exp_q.push_back(2006);
        exp_q.push_back(4000);
`else
        exp_q.push_back(6000);
        exp_q.push_back(2015);
        exp_q.push_back(4000);
`endif
        send(12'h005);
        repeat (3) @(negedge clock);
        #1;
        send(12'h002);
        drain(100);
        repeat (5) @(negedge clock);
        #1;
        check("final_idle", int'(state), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/move_command_executor.md
Name: move_command_executor

Overview:
- Rover-side consumer of the 12-bit move_command produced by the main FPGA's path/orientation logic.
- Latches one command, turns in place by a quantised angle, then drives forward a quantised distance. Reports completion with move_done.
- Sits between the command link receiver and the motor H-bridge drivers on the rover board.

Parameters:
- TURN_TICKS, 1350000, clock cycles per 15-degree turn step (50 ms at 27 MHz).
- UNIT_TICKS, 2700000, clock cycles per forward distance unit (100 ms at 27 MHz).
- PAUSE_TICKS, 270000, motors-stopped cycles between the turn phase and the drive phase.

Ports:
- clock  in  1  system clock, 27 MHz.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  single-cycle strobe; move_command is valid this cycle.
- move_command  in  12  [11:7] turn index (clockwise, 15-degree steps, legal 0-23); [6:0] forward distance in units (0-127).
- busy  out  1  high while a command is executing.
- move_done  out  1  one-cycle pulse when a command completes.
- cmd_error  out  1  one-cycle pulse when an illegal command is rejected.
- cmd_dropped  out  1  one-cycle pulse when a command arrives while busy and is not accepted.
- motor_left  out  2  00 stop, 01 forward, 10 reverse; 11 is never driven.
- motor_right  out  2  same encoding as motor_left.
- state  out  3  current FSM state, for debug.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all outputs 0; motors 00; counters and latched command cleared.
- State encoding: IDLE=0, TURN=1, PAUSE=2, DRIVE=3, DONE=4.
- IDLE:
  - On a clock edge with cmd_valid=1, latch move_command.
  - Turn index >23: stay in IDLE, pulse cmd_error the next cycle, no motion.
  - Otherwise select the next state: TURN if index!=0; else DRIVE if distance!=0; else DONE.
  - busy rises the cycle after acceptance.
- TURN:
  - motor_left=01, motor_right=10.
  - Lasts exactly index*TURN_TICKS cycles. Implement with a step counter plus a tick counter; no multiplier.
  - Exit to PAUSE if distance!=0, else to DONE.
- PAUSE: motors 00 for exactly PAUSE_TICKS cycles, then DRIVE.
- DRIVE: both motors 01 for exactly distance*UNIT_TICKS cycles, then DONE.
- DONE:
  - Motors 00; move_done=1 for this single cycle; busy=0 in this cycle.
  - Return to IDLE.
  - A cmd_valid arriving in DONE is treated as arriving while busy.
- Latency:
  - Motor outputs change on the first edge after acceptance.
  - The zero command (12'h000) produces move_done exactly 1 cycle after the accept edge.
- Every motor-phase length is exact, with no off-by-one. The bench counts cycles of each non-00 motor pattern.
- cmd_valid while busy (TURN, PAUSE, DRIVE, DONE): the command is ignored and cmd_dropped pulses the next cycle. Default build only.
- Motors are registered outputs, so no glitches. Both motors go to 00 on any state change into PAUSE, DONE or IDLE.
- Reset asserted mid-operation: motors go to 00 immediately (asynchronously); the in-flight command is lost; no move_done is issued.
- Counter width is 32 bits; parameters must satisfy 127*UNIT_TICKS < 2^32.

Optional Feature:
- Macro: CMD_QUEUE_EN.
- Defined:
  - A one-deep holding register captures a cmd_valid received while busy.
  - A second command arriving while the holding register is full is dropped with cmd_dropped.
  - On leaving DONE, a held command is accepted exactly as if it were strobed in IDLE that cycle, including the legality check.
  - Reset clears the holding register.
- Undefined: no holding register; every command received while busy is dropped with cmd_dropped.

Test Plan (TURN_TICKS=4, UNIT_TICKS=3, PAUSE_TICKS=2):
- cmd 12'h005 -> both motors 01 for exactly 15 cycles, then move_done for 1 cycle; busy high throughout.
- cmd 12'h100 (index 2, distance 0) -> motor_left=01/motor_right=10 for 8 cycles, no PAUSE/DRIVE, then move_done.
- cmd 12'h183 (index 3, distance 3) -> turn 12 cycles, motors 00 for 2 cycles, forward 9 cycles, move_done; state sequence 1,2,3,4,0.
- cmd 12'hC00 (index 24) -> cmd_error pulse, busy stays 0, motors stay 00; cmd 12'h000 -> move_done 1 cycle after accept.
- cmd 12'h07F, assert reset at drive cycle 50 -> motors 00 immediately, no move_done; after release a new 12'h001 executes normally (3 cycles).
- cmd 12'h005 then 12'h002 at cycle 5:
  - Undefined build -> cmd_dropped pulse; only 15 drive cycles occur.
  - CMD_QUEUE_EN build -> second command runs 6 cycles after the first completes; two move_done pulses.
